// File: rtl/cbus_arbiter.sv
`timescale 1ns/1ps
// cbus_arbiter: two-master CBus arbiter (I-cache, D-cache) onto one memory port, burst-locked, with stall watchdog.
// Optional feature: define CBUS_ARB_RR_EN for round-robin contention; undefined gives fixed D-cache priority.
package cbus_pkg;
    typedef logic [3:0] cbus_len_t;
    localparam cbus_len_t MLEN1  = 4'd0;
    localparam cbus_len_t MLEN2  = 4'd1;
    localparam cbus_len_t MLEN4  = 4'd3;
    localparam cbus_len_t MLEN8  = 4'd7;
    localparam cbus_len_t MLEN16 = 4'd15;

    typedef struct packed {
        logic        valid;
        logic        is_write;
        logic [31:0] addr;
        logic [2:0]  size;
        cbus_len_t   len;
        logic [7:0]  strobe;
        logic [63:0] data;
    } cbus_req_t;

    typedef struct packed {
        logic        ready;
        logic        last;
        logic [63:0] data;
    } cbus_resp_t;
endpackage

module cbus_arbiter
    import cbus_pkg::*;
#(
    parameter int unsigned WDOG_CYCLES = 1023
) (
    input  logic       clk,
    input  logic       reset,
    input  cbus_req_t  icreq,
    output cbus_resp_t icresp,
    input  cbus_req_t  dcreq,
    output cbus_resp_t dcresp,
    output cbus_req_t  oreq,
    input  cbus_resp_t oresp,
    output logic [1:0] owner,
    output logic       err
);
    // One-hot grant encoding so bit gi of the state is "master gi owns the port".
    localparam logic [1:0] IDLE  = 2'b00;
    localparam logic [1:0] GNT_I = 2'b01;
    localparam logic [1:0] GNT_D = 2'b10;
    localparam logic [15:0] WDOG_LIMIT = 16'(WDOG_CYCLES);

    logic [1:0]  state_reg, state_next;
    logic        last_owner_reg, last_owner_next;   // 0 = I, 1 = D
    logic [15:0] wdog_reg, wdog_next;
    logic        err_reg, err_next;
    logic [1:0]  contend_gnt;
    cbus_resp_t  mresp [2];

`ifdef CBUS_ARB_RR_EN
    assign contend_gnt = last_owner_reg ? GNT_I : GNT_D;
`else
    assign contend_gnt = GNT_D;
`endif

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_route
            assign mresp[gi] = state_reg[gi] ? oresp : '0;
        end
    endgenerate

    assign icresp = mresp[0];
    assign dcresp = mresp[1];
    assign owner  = state_reg;
    assign err    = err_reg;

    always_comb begin
        oreq = '0;
        if (state_reg == GNT_I) begin
            oreq = icreq;
        end else if (state_reg == GNT_D) begin
            oreq = dcreq;
        end
    end

    always_comb begin
        state_next      = state_reg;
        last_owner_next = last_owner_reg;
        case (state_reg)
            IDLE: begin
                if (icreq.valid && dcreq.valid) begin
                    state_next = contend_gnt;
                end else if (dcreq.valid) begin
                    state_next = GNT_D;
                end else if (icreq.valid) begin
                    state_next = GNT_I;
                end
            end
            GNT_I, GNT_D: begin
                // oreq carries the owner's request here, so !oreq.valid means an abandoned burst.
                if ((oresp.ready && oresp.last) || !oreq.valid) begin
                    state_next      = IDLE;
                    last_owner_next = state_reg[1];
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        wdog_next = wdog_reg;
        err_next  = err_reg;
        if ((state_reg == IDLE) || oresp.ready) begin
            wdog_next = '0;
        end else if (wdog_reg != 16'hFFFF) begin
            wdog_next = wdog_reg + 16'd1;
        end
        if ((state_reg != IDLE) && (wdog_next == WDOG_LIMIT)) begin
            err_next = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg      <= IDLE;
            last_owner_reg <= 1'b0;
            wdog_reg       <= '0;
            err_reg        <= 1'b0;
        end else begin
            state_reg      <= state_next;
            last_owner_reg <= last_owner_next;
            wdog_reg       <= wdog_next;
            err_reg        <= err_next;
        end
    end
endmodule
